// File: rtl/random_request_arbiter.sv
// Round-robin arbiter that shares one LFSR word among NUM_REQ requesters and reduces it to
// [0, limit-1] by mask-and-reject. Optional macro RNG_ARB_NO_REPEAT_EN forbids per-requester repeats.
module random_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RAND_BITS = 32,
  parameter int OUT_BITS  = 8,
  parameter int MAX_RETRY = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RAND_BITS-1:0]        lfsr_value,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*OUT_BITS-1:0] limit,
  output logic [NUM_REQ-1:0]          ack,
  output logic [OUT_BITS-1:0]         rand_out,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RET_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Handshake: req[i] is held until ack[i]; ack is a registered one-cycle pulse and
  // rand_out is valid in that cycle and holds until the next ack.
  state_t              r_state, w_state;
  logic [IDX_W-1:0]    r_rr, w_rr, r_winner, w_winner, w_pick;
  logic [OUT_BITS-1:0] r_limit, w_limit, r_mask, w_mask, r_cand, w_cand;
  logic [OUT_BITS-1:0] r_result, w_result, r_rand_out, w_rand_out;
  logic [OUT_BITS-1:0] w_sel_limit, w_lim_m1, w_new_mask;
  logic [RET_W-1:0]    r_retry, w_retry;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  logic                w_found, w_accept, w_repeat;

  generate
    if (RAND_BITS > OUT_BITS) begin : g_unused
      logic w_unused_lfsr;
      assign w_unused_lfsr = ^lfsr_value[RAND_BITS-1:OUT_BITS];
    end
  endgenerate

  // First set request scanning upward from the requester after the last winner.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = r_rr;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(r_rr) + off) % NUM_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  // Smearing (limit-1) rightward yields 2^k-1 with 2^k >= limit; limit 0 wraps to all ones.
  always_comb begin
    w_sel_limit = limit[int'(w_pick)*OUT_BITS +: OUT_BITS];
    w_lim_m1    = w_sel_limit - OUT_BITS'(1);
    w_new_mask  = w_lim_m1;
    for (int s = 1; s < OUT_BITS; s++) begin
      w_new_mask = w_new_mask | (w_lim_m1 >> s);
    end
  end

`ifdef RNG_ARB_NO_REPEAT_EN
  logic [OUT_BITS-1:0] r_last [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) r_last[i] <= '0;
    end else if (r_state == S_DONE) begin
      r_last[r_winner] <= r_result;
    end
  end

  assign w_repeat = (r_cand == r_last[r_winner]) && (r_limit != OUT_BITS'(1));
`else
  assign w_repeat = 1'b0;
`endif

  assign w_accept = ((r_limit == '0) || (r_cand < r_limit)) && !w_repeat;

  always_comb begin
    w_state    = r_state;
    w_rr       = r_rr;
    w_winner   = r_winner;
    w_limit    = r_limit;
    w_mask     = r_mask;
    w_cand     = r_cand;
    w_result   = r_result;
    w_retry    = r_retry;
    w_rand_out = r_rand_out;
    w_ack      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_winner = w_pick;
          w_limit  = w_sel_limit;
          w_mask   = w_new_mask;
          w_retry  = '0;
          w_state  = S_DRAW;
        end
      end
      S_DRAW: begin
        w_cand  = lfsr_value[OUT_BITS-1:0] & r_mask;
        w_state = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) begin
          w_result = r_cand;
          w_state  = S_DONE;
        end else if (r_retry == RET_W'(MAX_RETRY)) begin
          // Dropping the top mask bit guarantees a value below limit.
          w_result = r_cand & (r_mask >> 1);
          w_state  = S_DONE;
        end else begin
          w_retry = r_retry + RET_W'(1);
          w_state = S_DRAW;
        end
      end
      S_DONE: begin
        w_ack      = NUM_REQ'(1) << r_winner;
        w_rand_out = r_result;
        w_rr       = r_winner;
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr       <= IDX_W'(NUM_REQ - 1);
      r_winner   <= '0;
      r_limit    <= '0;
      r_mask     <= '0;
      r_cand     <= '0;
      r_result   <= '0;
      r_retry    <= '0;
      r_rand_out <= '0;
      r_ack      <= '0;
    end else begin
      r_state    <= w_state;
      r_rr       <= w_rr;
      r_winner   <= w_winner;
      r_limit    <= w_limit;
      r_mask     <= w_mask;
      r_cand     <= w_cand;
      r_result   <= w_result;
      r_retry    <= w_retry;
      r_rand_out <= w_rand_out;
      r_ack      <= w_ack;
    end
  end

  assign ack       = r_ack;
  assign rand_out  = r_rand_out;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_random_request_arbiter.sv
// Directed bench for random_request_arbiter: reset, round-robin order, fallback draws,
// range reduction, mid-draw changes and repeat behaviour (RNG_ARB_NO_REPEAT_EN aware).
module tb_random_request_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lfsr_value;
  logic [3:0]  req;
  logic [31:0] limit;
  logic [3:0]  ack;
  logic [7:0]  rand_out;
  logic        busy;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lfsr_mode = 0;  // 0: function of cycle, 1: forced word, 2: random
  logic [31:0] force_val = '0;
  logic [31:0] rnd_val   = '0;
  logic [7:0]  exp_q[$];

  random_request_arbiter #(
    .NUM_REQ(4), .RAND_BITS(32), .OUT_BITS(8), .MAX_RETRY(7)
  ) dut (
    .clk(clk), .reset(reset), .lfsr_value(lfsr_value), .req(req), .limit(limit),
    .ack(ack), .rand_out(rand_out), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset and LFSR stand-in
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_val <= $urandom;
  end

  function automatic logic [31:0] gen(input int n);
    logic [31:0] v;
    v = 32'(n) * 32'h9E37_79B1 + 32'h0123_4567;
    return v ^ (v >> 13);
  endfunction

  always_comb begin
    case (lfsr_mode)
      0:       lfsr_value = gen(cyc);
      1:       lfsr_value = force_val;
      default: lfsr_value = rnd_val;
    endcase
  end

  task automatic wait_ack(input int max_cyc, output logic [3:0] got);
    int waited;
    got    = '0;
    waited = 0;
    while (got == '0 && waited < max_cyc) begin
      @(negedge clk);
      waited++;
      got = ack;
    end
    if (got == '0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: no ack within %0d cycles, required an ack", max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; limit = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ack !== 4'b0 || rand_out !== 8'h00 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b rand_out=%h busy=%b state=%0d, required 0000/00/0/0",
               ack, rand_out, busy, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b ack=%b, required 0/0000", busy, ack);
    end
  endtask

  task automatic test_round_robin();
    int          c;
    logic [31:0] g;
    logic [7:0]  e;
    logic [3:0]  exp_a;
    lfsr_mode = 0; limit = '0;
    c = cyc;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = gen(c + 1 + 4 * k);
      exp_q.push_back(g[7:0]);
    end
    for (int k = 0; k < 5; k++) begin
      for (int j = 1; j < 4; j++) begin
        @(negedge clk);
        n_tests++;
        if (ack !== 4'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_gap%0d_%0d: ack=%b busy=%b, required 0000/1", k, j, ack, busy);
        end
      end
      @(negedge clk);
      exp_a = 4'b0001 << (k % 4);
      e = exp_q.pop_front();
      n_tests++;
      if (ack !== exp_a || rand_out !== e || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ack=%b rand_out=%h busy=%b, required %b/%h/0",
                 k, ack, rand_out, busy, exp_a, e);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_check();
    int          c;
    logic [31:0] g;
    lfsr_mode = 0; limit = '0;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_check_state: state=%0d, required 2", dbg_state);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ack !== 4'b0 || busy !== 1'b0 || rand_out !== 8'h00 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_check_reset: ack=%b busy=%b rand_out=%h state=%0d, required 0000/0/00/0",
               ack, busy, rand_out, dbg_state);
    end
    reset = 1'b0;
    c = cyc;
    g = gen(c + 1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (ack !== 4'b0001 || rand_out !== g[7:0]) begin
      n_fail++;
      $display("FAIL after_reset_grant: ack=%b rand_out=%h, required 0001/%h", ack, rand_out, g[7:0]);
    end
    req = '0;
  endtask

  task automatic test_forced(input string name, input int idx, input logic [7:0] lim,
                             input logic [7:0] low, input logic [7:0] exp_v, input int exp_lat);
    logic [3:0] exp_a;
    exp_a = 4'b0001 << idx;
    lfsr_mode = 1;
    force_val = {24'hC0FFEE, low};
    limit[idx*8 +: 8] = lim;
    req = exp_a;
    for (int j = 1; j < exp_lat; j++) begin
      @(negedge clk);
      n_tests++;
      if (ack !== 4'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_wait%0d: ack=%b busy=%b, required 0000/1", name, j, ack, busy);
      end
    end
    @(negedge clk);
    n_tests++;
    if (ack !== exp_a || rand_out !== exp_v || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: ack=%b rand_out=%h busy=%b, required %b/%h/0",
               name, ack, rand_out, busy, exp_a, exp_v);
    end
    req = '0;
    lfsr_mode = 0;
  endtask

  task automatic test_range(input int idx, input logic [7:0] lim, input int draws, input int min_hits);
    int         hist [256];
    logic [3:0] exp_a, got;
    for (int v = 0; v < 256; v++) hist[v] = 0;
    exp_a = 4'b0001 << idx;
    lfsr_mode = 2;
    limit[idx*8 +: 8] = lim;
    req = exp_a;
    for (int d = 0; d < draws; d++) begin
      wait_ack(40, got);
      if (got == '0) break;
      n_tests++;
      if (got !== exp_a || rand_out >= lim) begin
        n_fail++;
        $display("FAIL range_lim%0d_draw%0d: ack=%b rand_out=%0d, required %b/<%0d",
                 lim, d, got, rand_out, exp_a, lim);
      end
      hist[rand_out]++;
    end
    req = '0;
    for (int v = 0; v < int'(lim); v++) begin
      n_tests++;
      if (hist[v] < min_hits) begin
        n_fail++;
        $display("FAIL hist_lim%0d_val%0d: hits=%0d, required >=%0d", lim, v, hist[v], min_hits);
      end
    end
    lfsr_mode = 0;
  endtask

  task automatic test_mid_draw_changes();
    int          c;
    logic [31:0] g;
    lfsr_mode = 0; limit = '0;
    c = cyc;
    g = gen(c + 1);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0110;
    limit[15:8] = 8'd1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ack !== 4'b0100 || rand_out !== g[7:0]) begin
      n_fail++;
      $display("FAIL late_req_first: ack=%b rand_out=%h, required 0100/%h", ack, rand_out, g[7:0]);
    end
    req = 4'b0010;
    @(negedge clk);
    limit[15:8] = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ack !== 4'b0010 || rand_out !== 8'h00) begin
      n_fail++;
      $display("FAIL late_req_second: ack=%b rand_out=%h, required 0010/00", ack, rand_out);
    end
    req = '0;
  endtask

  task automatic test_repeat();
    logic [3:0] got;
    logic [7:0] prev;
    int         reps;
    prev = 8'hFF;
    reps = 0;
    lfsr_mode = 2;
    limit[7:0] = 8'd2;
    req = 4'b0001;
    for (int d = 0; d < 200; d++) begin
      wait_ack(40, got);
      if (got == '0) break;
      n_tests++;
      if (got !== 4'b0001 || rand_out > 8'd1) begin
        n_fail++;
        $display("FAIL repeat_draw%0d: ack=%b rand_out=%0d, required 0001/<2", d, got, rand_out);
      end
`ifdef RNG_ARB_NO_REPEAT_EN
      n_tests++;
      if (prev == 8'd1 && rand_out == 8'd1) begin
        n_fail++;
        $display("FAIL no_repeat_draw%0d: rand_out=1 after 1, required 0", d);
      end
`endif
      if (rand_out == prev) reps++;
      prev = rand_out;
    end
    req = '0;
`ifndef RNG_ARB_NO_REPEAT_EN
    n_tests++;
    if (reps == 0) begin
      n_fail++;
      $display("FAIL repeats_allowed: repeats=%0d, required >0", reps);
    end
`endif
    lfsr_mode = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_reset_mid_check();
    test_forced("fallback_lim10",  1, 8'd10,  8'h0A, 8'h02, 18);
    test_forced("fallback_lim255", 2, 8'd255, 8'hFF, 8'h7F, 18);
    test_forced("accept_lim10",    1, 8'd10,  8'h09, 8'h09, 4);
    test_forced("mask_lim128",     3, 8'd128, 8'h80, 8'h00, 4);
    test_forced("full_range",      0, 8'd0,   8'hFF, 8'hFF, 4);
    test_forced("lim1_forced",     2, 8'd1,   8'hFF, 8'h00, 4);
    test_forced("lim2_mask",       0, 8'd2,   8'h03, 8'h01, 4);
    test_range(3, 8'd1, 1000, 1000);
    test_range(1, 8'd6, 1000, 100);
    test_mid_draw_changes();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
